// File: rtl/modexp_controller_if.sv
// Bundles the request/response and modulus-unit handshake of modexp_controller.
// Signal names keep the controller's point of view (_in = into controller, _out = out of it).
// master: requester plus attached modulus unit; slave: the controller itself.
// Optional MODEXP_OPCOUNT_EN adds op_count_out (issued-transaction counter).
interface modexp_controller_if #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
);
  // requester side
  logic                   start_in;
  logic [WIDTH-1:0]       base_in;
  logic [EXP_WIDTH-1:0]   exponent_in;
  logic [WIDTH-1:0]       modulus_in;
  logic [WIDTH-1:0]       result_out;
  logic                   busy_out;
  logic                   valid_out;
  // modulus reduction unit side
  logic                   mod_ready_out;
  logic [2*WIDTH-1:0]     mod_value_out;
  logic [WIDTH-1:0]       mod_modulus_out;
  logic [WIDTH-1:0]       mod_value_in;
  logic                   mod_busy_in;
  logic                   mod_valid_in;
`ifdef MODEXP_OPCOUNT_EN
  logic [15:0]            op_count_out;

  modport master (
    output start_in, base_in, exponent_in, modulus_in,
    output mod_value_in, mod_busy_in, mod_valid_in,
    input  result_out, busy_out, valid_out,
    input  mod_ready_out, mod_value_out, mod_modulus_out,
    input  op_count_out
  );

  modport slave (
    input  start_in, base_in, exponent_in, modulus_in,
    input  mod_value_in, mod_busy_in, mod_valid_in,
    output result_out, busy_out, valid_out,
    output mod_ready_out, mod_value_out, mod_modulus_out,
    output op_count_out
  );
`else
  modport master (
    output start_in, base_in, exponent_in, modulus_in,
    output mod_value_in, mod_busy_in, mod_valid_in,
    input  result_out, busy_out, valid_out,
    input  mod_ready_out, mod_value_out, mod_modulus_out
  );

  modport slave (
    input  start_in, base_in, exponent_in, modulus_in,
    input  mod_value_in, mod_busy_in, mod_valid_in,
    output result_out, busy_out, valid_out,
    output mod_ready_out, mod_value_out, mod_modulus_out
  );
`endif
endinterface

// File: rtl/modexp_controller.sv
// Purpose: square-and-multiply sequencer computing base^exp mod m using an external modulus unit.
// Latency: 1 + popcount(e) + bitlen(e)-1 reductions, each modulus latency + 2 cycles, plus 2 cycles start/finish.
// Backpressure: an issue stalls while mod_busy_in is high; start_in is ignored unless idle.
// Ports: clk_in, rst_in (async active-low) plus interface bus (slave modport):
//   start_in/base_in/exponent_in/modulus_in -> result_out/busy_out/valid_out,
//   mod_ready_out/mod_value_out/mod_modulus_out -> mod_value_in/mod_busy_in/mod_valid_in.
// Optional build macro MODEXP_OPCOUNT_EN adds op_count_out[15:0] (saturating issue count).
module modexp_controller #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  modexp_controller_if.slave  bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REDUCE = 3'd1;
  localparam logic [2:0] LOOP   = 3'd2;
  localparam logic [2:0] ISSUE  = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [1:0] OP_RED = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_SQR = 2'd2;

  logic [2:0]           state_q,     state_d;
  logic [1:0]           op_q,        op_d;
  logic                 mul_done_q,  mul_done_d;
  logic [WIDTH-1:0]     acc_q,       acc_d;
  logic [WIDTH-1:0]     b_q,         b_d;
  logic [EXP_WIDTH-1:0] e_q,         e_d;
  logic [WIDTH-1:0]     m_q,         m_d;
  logic [WIDTH-1:0]     result_q,    result_d;
  logic                 busy_q,      busy_d;
  logic                 valid_q,     valid_d;
  logic                 mod_ready_q, mod_ready_d;
  logic [2*WIDTH-1:0]   mod_value_q, mod_value_d;
`ifdef MODEXP_OPCOUNT_EN
  logic [15:0]          op_count_q,  op_count_d;
`endif

  // Operands are zero-extended so the multiply is a full 2*WIDTH-bit product.
  logic [2*WIDTH-1:0]   acc_x;
  logic [2*WIDTH-1:0]   b_x;
  logic [2*WIDTH-1:0]   product;

  always_comb begin
    acc_x = {{WIDTH{1'b0}}, acc_q};
    b_x   = {{WIDTH{1'b0}}, b_q};
    case (op_q)
      OP_RED:  product = b_x;
      OP_MUL:  product = acc_x * b_x;
      default: product = b_x * b_x;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mul_done_d  = mul_done_q;
    acc_d       = acc_q;
    b_d         = b_q;
    e_d         = e_q;
    m_d         = m_q;
    result_d    = result_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    mod_ready_d = 1'b0;
    mod_value_d = mod_value_q;
`ifdef MODEXP_OPCOUNT_EN
    op_count_d  = op_count_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          b_d        = bus.base_in;
          e_d        = bus.exponent_in;
          m_d        = bus.modulus_in;
          // acc starts at 1, but at 0 for m<=1 so that m==1 and the m==0
          // shortcut both finish with result 0.
          acc_d      = {{(WIDTH-1){1'b0}}, |bus.modulus_in[WIDTH-1:1]};
          mul_done_d = 1'b0;
          busy_d     = 1'b1;
`ifdef MODEXP_OPCOUNT_EN
          op_count_d = 16'd0;
`endif
          if (bus.modulus_in == '0 || bus.exponent_in == '0) begin
            state_d = DONE;
          end else begin
            state_d = REDUCE;
          end
        end
      end

      REDUCE: begin
        // First transaction brings the base into range so every later
        // operand is already < m.
        op_d    = OP_RED;
        state_d = ISSUE;
      end

      LOOP: begin
        if (e_q[0] && !mul_done_q) begin
          op_d    = OP_MUL;
          state_d = ISSUE;
        end else if (|e_q[EXP_WIDTH-1:1]) begin
          op_d    = OP_SQR;
          state_d = ISSUE;
        end else begin
          // Last exponent bit consumed; the trailing square would be unused.
          state_d = DONE;
        end
      end

      ISSUE: begin
        if (!bus.mod_busy_in) begin
          mod_value_d = product;
          mod_ready_d = 1'b1;
          state_d     = WAIT;
`ifdef MODEXP_OPCOUNT_EN
          if (op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
          end
`endif
        end
      end

      WAIT: begin
        if (bus.mod_valid_in) begin
          case (op_q)
            OP_RED: b_d = bus.mod_value_in;
            OP_MUL: begin
              acc_d      = bus.mod_value_in;
              mul_done_d = 1'b1;
            end
            default: begin
              b_d        = bus.mod_value_in;
              e_d        = e_q >> 1;
              mul_done_d = 1'b0;
            end
          endcase
          state_d = LOOP;
        end
      end

      DONE: begin
        result_d = acc_q;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      op_q        <= OP_RED;
      mul_done_q  <= 1'b0;
      acc_q       <= '0;
      b_q         <= '0;
      e_q         <= '0;
      m_q         <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      mod_ready_q <= 1'b0;
      mod_value_q <= '0;
`ifdef MODEXP_OPCOUNT_EN
      op_count_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mul_done_q  <= mul_done_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      e_q         <= e_d;
      m_q         <= m_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      mod_ready_q <= mod_ready_d;
      mod_value_q <= mod_value_d;
`ifdef MODEXP_OPCOUNT_EN
      op_count_q  <= op_count_d;
`endif
    end
  end

  assign bus.result_out      = result_q;
  assign bus.busy_out        = busy_q;
  assign bus.valid_out       = valid_q;
  assign bus.mod_ready_out   = mod_ready_q;
  assign bus.mod_value_out   = mod_value_q;
  assign bus.mod_modulus_out = m_q;
`ifdef MODEXP_OPCOUNT_EN
  assign bus.op_count_out    = op_count_q;
`endif

endmodule

// File: tb/tb_modexp_controller.sv
// Scoreboard bench for modexp_controller with a behavioural modulus unit.
// Stimulus pushes expected {result, transaction count}; a negedge monitor
// pops on every valid_out and also watches the reduction handshake.
module tb_modexp_controller;
  localparam int W   = 16;
  localparam int EW  = 16;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  modexp_controller_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus();

  modexp_controller #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  logic          start = 1'b0;
  logic [W-1:0]  base_v = '0;
  logic [EW-1:0] exp_v = '0;
  logic [W-1:0]  mod_v = '0;
  logic          force_busy = 1'b0;
  logic          model_busy, model_valid;
  logic [W-1:0]  model_value;
  logic [2*W-1:0] model_hold;
  int            model_cnt;

  assign bus.start_in     = start;
  assign bus.base_in      = base_v;
  assign bus.exponent_in  = exp_v;
  assign bus.modulus_in   = mod_v;
  assign bus.mod_busy_in  = model_busy | force_busy;
  assign bus.mod_valid_in = model_valid;
  assign bus.mod_value_in = model_value;

  // Behavioural modulus unit: fixed latency, busy while reducing.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy  <= 1'b0;
      model_valid <= 1'b0;
      model_value <= '0;
      model_hold  <= '0;
      model_cnt   <= 0;
    end else begin
      model_valid <= 1'b0;
      if (bus.mod_ready_out) begin
        model_busy <= 1'b1;
        model_cnt  <= LAT;
        if (bus.mod_modulus_out == '0) model_hold <= '0;
        else model_hold <= bus.mod_value_out % {{W{1'b0}}, bus.mod_modulus_out};
      end else if (model_busy) begin
        if (model_cnt == 1) begin
          model_busy  <= 1'b0;
          model_valid <= 1'b1;
          model_value <= model_hold[W-1:0];
        end
        model_cnt <= model_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [W-1:0] res;
    int           ops;
    int           base_cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int ready_total = 0;
  logic prev_busy = 1'b0;
  logic in_flight = 1'b0;
  logic [2*W-1:0] held = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: scoreboard pop on completion, handshake rules on the modulus side.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_flight = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (bus.mod_ready_out) begin
        ready_total++;
        chk("issue_while_busy", {63'd0, prev_busy}, 64'd0);
        held      = bus.mod_value_out;
        in_flight = 1'b1;
      end else if (in_flight) begin
        chk("mod_value_stable", {32'd0, bus.mod_value_out}, {32'd0, held});
      end
      if (bus.mod_valid_in) in_flight = 1'b0;
      if (bus.valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result", {48'd0, bus.result_out}, {48'd0, e.res});
          chk("busy_in_valid_cycle", {63'd0, bus.busy_out}, 64'd0);
          chk("transactions", 64'(ready_total - e.base_cnt), 64'(e.ops));
`ifdef MODEXP_OPCOUNT_EN
          chk("op_count", {48'd0, bus.op_count_out}, 64'(e.ops));
`endif
        end
      end
      prev_busy = bus.mod_busy_in;
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_op(input logic [W-1:0] b, input logic [EW-1:0] x,
                          input logic [W-1:0] m, input logic [W-1:0] res, input int ops);
    exp_t e;
    e.res      = res;
    e.ops      = ops;
    e.base_cnt = ready_total;
    sb.push_back(e);
    start  = 1'b1;
    base_v = b;
    exp_v  = x;
    mod_v  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout with %0d pending, required 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int snap;
    repeat (3) @(negedge clk);
    chk("rst_result", {48'd0, bus.result_out}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy_out}, 64'd0);
    chk("rst_valid", {63'd0, bus.valid_out}, 64'd0);
    chk("rst_ready", {63'd0, bus.mod_ready_out}, 64'd0);
    chk("rst_value", {32'd0, bus.mod_value_out}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3^5 mod 7
    start_op(16'd3, 16'd5, 16'd7, 16'd5, 5);
    chk("busy_after_start", {63'd0, bus.busy_out}, 64'd1);
    drain("t1");

    // 2^10 mod 1000, then 20^2 mod 7 (base must be reduced to 6 first)
    start_op(16'd2, 16'd10, 16'd1000, 16'd24, 6);
    drain("t2a");
    start_op(16'd20, 16'd2, 16'd7, 16'd1, 3);
    drain("t2b");

    // exponent 0, modulus 1, modulus 0
    start_op(16'd9, 16'd0, 16'd7, 16'd1, 0);
    drain("t3a");
    start_op(16'd5, 16'd4, 16'd1, 16'd0, 4);
    drain("t3b");
    start_op(16'd5, 16'd5, 16'd0, 16'd0, 0);
    drain("t3c");

    // start while busy is ignored
    start_op(16'd3, 16'd5, 16'd7, 16'd5, 5);
    repeat (3) @(negedge clk);
    start = 1'b1; base_v = 16'd2; exp_v = 16'd3; mod_v = 16'd11;
    @(negedge clk);
    start = 1'b0;
    chk("modulus_kept", {48'd0, bus.mod_modulus_out}, 64'd7);
    drain("t4a");
    start_op(16'd2, 16'd3, 16'd11, 16'd8, 4);
    drain("t4b");

    // modulus unit held busy before the first issue
    force_busy = 1'b1;
    snap = ready_total;
    start_op(16'd3, 16'd5, 16'd7, 16'd5, 5);
    repeat (10) @(negedge clk);
    chk("no_issue_while_busy", 64'(ready_total - snap), 64'd0);
    force_busy = 1'b0;
    drain("t5");

    // reset while waiting for a reduction
    start_op(16'd3, 16'd5, 16'd7, 16'd5, 5);
    for (int i = 0; i < 200 && !model_busy; i++) @(negedge clk);
    chk("reached_wait", {63'd0, model_busy}, 64'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_result", {48'd0, bus.result_out}, 64'd0);
    chk("mid_rst_busy", {63'd0, bus.busy_out}, 64'd0);
    chk("mid_rst_valid", {63'd0, bus.valid_out}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.mod_ready_out}, 64'd0);
    chk("mid_rst_value", {32'd0, bus.mod_value_out}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    start_op(16'd3, 16'd5, 16'd7, 16'd5, 5);
    drain("t6");

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
